// File: rtl/q_perm_pipe_pkg.sv
// Shared definitions for the Twofish q-permutation pipeline: nibble t-boxes,
// lane mode encodings and the small 4-bit mixing helpers.
package q_perm_pkg;

    localparam logic Q_MODE_Q0 = 1'b0;
    localparam logic Q_MODE_Q1 = 1'b1;

    localparam logic [3:0] Q0_T0 [0:15] = '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
                                            4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
    localparam logic [3:0] Q0_T1 [0:15] = '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
                                            4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
    localparam logic [3:0] Q0_T2 [0:15] = '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
                                            4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
    localparam logic [3:0] Q0_T3 [0:15] = '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
                                            4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};
    localparam logic [3:0] Q1_T0 [0:15] = '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
                                            4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5};
    localparam logic [3:0] Q1_T1 [0:15] = '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
                                            4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8};
    localparam logic [3:0] Q1_T2 [0:15] = '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
                                            4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF};
    localparam logic [3:0] Q1_T3 [0:15] = '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
                                            4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA};

    function automatic logic [3:0] ror4(input logic [3:0] x);
        return {x[0], x[3:1]};
    endfunction

    function automatic logic [3:0] mul8mod16(input logic [3:0] x);
        return {x[0], 3'b000};
    endfunction

    // sel picks t0..t3; round 1 uses t0/t1, round 2 uses t2/t3.
    function automatic logic [3:0] tbox(input logic mode, input logic [1:0] sel,
                                        input logic [3:0] idx);
        logic [3:0] r;
        case ({mode, sel})
            {Q_MODE_Q0, 2'd0}: r = Q0_T0[idx];
            {Q_MODE_Q0, 2'd1}: r = Q0_T1[idx];
            {Q_MODE_Q0, 2'd2}: r = Q0_T2[idx];
            {Q_MODE_Q0, 2'd3}: r = Q0_T3[idx];
            {Q_MODE_Q1, 2'd0}: r = Q1_T0[idx];
            {Q_MODE_Q1, 2'd1}: r = Q1_T1[idx];
            {Q_MODE_Q1, 2'd2}: r = Q1_T2[idx];
            {Q_MODE_Q1, 2'd3}: r = Q1_T3[idx];
            default:           r = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/q_perm_pipe_half.sv
// One mixing round of the q-permutation on a nibble pair: combine a/b,
// then substitute through the round's two t-boxes.
module q_perm_half
    import q_perm_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    input  logic       rnd,
    output logic [3:0] a_n,
    output logic [3:0] b_n
);

    logic [3:0] a_mix_s;
    logic [3:0] b_mix_s;

    // Mix and substitute for one round.
    always_comb begin
        a_mix_s = a ^ b;
        b_mix_s = a ^ ror4(b) ^ mul8mod16(a);
        a_n     = tbox(mode, {rnd, 1'b0}, a_mix_s);
        b_n     = tbox(mode, {rnd, 1'b1}, b_mix_s);
    end

endmodule

// File: rtl/q_perm_pipe.sv
// Multi-lane pipelined Twofish q0/q1 permutation with valid/ready flow control.
// Optional output transfer/stall counters are built when Q_PERM_PIPE_STATS_EN is defined.
module q_perm_pipe
    import q_perm_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data
`ifdef Q_PERM_PIPE_STATS_EN
    ,
    output logic [31:0]          stat_xfers,
    output logic [31:0]          stat_stalls
`endif
);

    logic [LANES-1:0][3:0] r1_a_s;
    logic [LANES-1:0][3:0] r1_b_s;
    logic [LANES-1:0][3:0] r2_in_a_s;
    logic [LANES-1:0][3:0] r2_in_b_s;
    logic [LANES-1:0]      r2_mode_s;
    logic [LANES-1:0][3:0] r2_a_s;
    logic [LANES-1:0][3:0] r2_b_s;
    logic [8*LANES-1:0]    perm_s;

    logic                  in_rdy_s;
    logic                  out_v_q;
    logic                  out_v_d;
    logic [8*LANES-1:0]    out_data_q;
    logic [8*LANES-1:0]    out_data_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        q_perm_half u_round1 (
            .a    (in_data[8*k+4 +: 4]),
            .b    (in_data[8*k   +: 4]),
            .mode (in_mode[k]),
            .rnd  (1'b0),
            .a_n  (r1_a_s[k]),
            .b_n  (r1_b_s[k])
        );
        q_perm_half u_round2 (
            .a    (r2_in_a_s[k]),
            .b    (r2_in_b_s[k]),
            .mode (r2_mode_s[k]),
            .rnd  (1'b1),
            .a_n  (r2_a_s[k]),
            .b_n  (r2_b_s[k])
        );
        assign perm_s[8*k +: 8] = {r2_b_s[k], r2_a_s[k]};
    end

    if (PIPE_STAGES == 2) begin : g_two
        logic [LANES-1:0][3:0] mid_a_q;
        logic [LANES-1:0][3:0] mid_a_d;
        logic [LANES-1:0][3:0] mid_b_q;
        logic [LANES-1:0][3:0] mid_b_d;
        logic [LANES-1:0]      mid_mode_q;
        logic [LANES-1:0]      mid_mode_d;
        logic                  mid_v_q;
        logic                  mid_v_d;
        logic                  out_adv_s;
        logic                  mid_adv_s;
        logic                  in_load_s;

        // Backpressure ripples combinationally from out_ready to in_ready.
        always_comb begin
            out_adv_s  = out_v_q && out_ready;
            mid_adv_s  = mid_v_q && (!out_v_q || out_adv_s);
            in_rdy_s   = !mid_v_q || mid_adv_s;
            in_load_s  = in_valid && in_rdy_s && !flush;
            mid_a_d    = mid_a_q;
            mid_b_d    = mid_b_q;
            mid_mode_d = mid_mode_q;
            out_data_d = out_data_q;
            if (flush) begin
                mid_v_d = 1'b0;
                out_v_d = 1'b0;
            end else begin
                mid_v_d = in_load_s ? 1'b1 : (mid_adv_s ? 1'b0 : mid_v_q);
                out_v_d = mid_adv_s ? 1'b1 : (out_adv_s ? 1'b0 : out_v_q);
            end
            if (in_load_s) begin
                mid_a_d    = r1_a_s;
                mid_b_d    = r1_b_s;
                mid_mode_d = in_mode;
            end else begin
                mid_a_d    = mid_a_q;
            end
            if (mid_adv_s && !flush) begin
                out_data_d = perm_s;
            end else begin
                out_data_d = out_data_q;
            end
        end

        // Round-1 result register between the two t-box rounds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mid_v_q    <= 1'b0;
                mid_a_q    <= '0;
                mid_b_q    <= '0;
                mid_mode_q <= '0;
            end else begin
                mid_v_q    <= mid_v_d;
                mid_a_q    <= mid_a_d;
                mid_b_q    <= mid_b_d;
                mid_mode_q <= mid_mode_d;
            end
        end

        assign r2_in_a_s = mid_a_q;
        assign r2_in_b_s = mid_b_q;
        assign r2_mode_s = mid_mode_q;
    end else begin : g_one
        logic out_adv_s;
        logic in_load_s;

        // Single stage: both rounds feed the output register directly.
        always_comb begin
            out_adv_s = out_v_q && out_ready;
            in_rdy_s  = !out_v_q || out_adv_s;
            in_load_s = in_valid && in_rdy_s && !flush;
            if (flush) begin
                out_v_d = 1'b0;
            end else begin
                out_v_d = in_load_s ? 1'b1 : (out_adv_s ? 1'b0 : out_v_q);
            end
            if (in_load_s) begin
                out_data_d = perm_s;
            end else begin
                out_data_d = out_data_q;
            end
        end

        assign r2_in_a_s = r1_a_s;
        assign r2_in_b_s = r1_b_s;
        assign r2_mode_s = in_mode;
    end

    // Output stage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = in_rdy_s;
    assign out_valid = out_v_q;
    assign out_data  = out_data_q;

`ifdef Q_PERM_PIPE_STATS_EN
    logic [31:0] xfers_q;
    logic [31:0] xfers_d;
    logic [31:0] stalls_q;
    logic [31:0] stalls_d;

    // Saturating counters of output transfers and output stall cycles.
    always_comb begin
        xfers_d  = xfers_q;
        stalls_d = stalls_q;
        if (flush) begin
            xfers_d  = 32'd0;
            stalls_d = 32'd0;
        end else begin
            if (out_v_q && out_ready && (xfers_q != 32'hFFFF_FFFF)) begin
                xfers_d = xfers_q + 32'd1;
            end else begin
                xfers_d = xfers_q;
            end
            if (out_v_q && !out_ready && (stalls_q != 32'hFFFF_FFFF)) begin
                stalls_d = stalls_q + 32'd1;
            end else begin
                stalls_d = stalls_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfers_q  <= 32'd0;
            stalls_q <= 32'd0;
        end else begin
            xfers_q  <= xfers_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_xfers  = xfers_q;
    assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_q_perm_pipe.sv
// Directed self-checking bench for q_perm_pipe (LANES=4, PIPE_STAGES=2).
module tb_q_perm_pipe;

    localparam logic [63:0] Q0T0 = 64'h817D6F320B59ECA4;
    localparam logic [63:0] Q0T1 = 64'hECB81235F4A6709D;
    localparam logic [63:0] Q0T2 = 64'hBA5E6D90C8F32471;
    localparam logic [63:0] Q0T3 = 64'hD7F4126E9B3085CA;
    localparam logic [63:0] Q1T0 = 64'h28BDF76E31940AC5;
    localparam logic [63:0] Q1T1 = 64'h1E2B4C376DA5F908;
    localparam logic [63:0] Q1T2 = 64'h4C75169A0ED82B3F;
    localparam logic [63:0] Q1T3 = 64'hB951C3DE647F208A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  in_mode = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
`ifdef Q_PERM_PIPE_STATS_EN
    logic [31:0] stat_xfers;
    logic [31:0] stat_stalls;
`endif

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          rand_en = 1'b0;
    logic [31:0] oq[$];
    int          oc[$];
    int          ic[$];
    logic [31:0] eq[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;

    q_perm_pipe #(.LANES(4), .PIPE_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef Q_PERM_PIPE_STATS_EN
        ,
        .stat_xfers  (stat_xfers),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] i);
        return t[63 - 4*int'(i) -: 4];
    endfunction

    function automatic logic [7:0] ref_q(input logic m, input logic [7:0] x);
        logic [3:0] a, b, a1, b1;
        a  = x[7:4];
        b  = x[3:0];
        a1 = a ^ b;
        b1 = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a  = nib(m ? Q1T0 : Q0T0, a1);
        b  = nib(m ? Q1T1 : Q0T1, b1);
        a1 = a ^ b;
        b1 = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a  = nib(m ? Q1T2 : Q0T2, a1);
        b  = nib(m ? Q1T3 : Q0T3, b1);
        return {b, a};
    endfunction

    // Monitor: records transfers and checks output hold under stall.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            if (in_valid && in_ready && !flush) ic.push_back(cyc);
            if (out_valid && out_ready) begin
                oq.push_back(out_data);
                oc.push_back(cyc);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic clear_q();
        oq.delete(); oc.delete(); ic.delete(); eq.delete();
    endtask

    // Call #1 after a posedge; returns #1 after the transfer edge.
    task automatic send(input logic [31:0] d, input logic [3:0] m);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input int n, input int budget);
        int k;
        k = 0;
        while (oq.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("out_count", 64'(oq.size()), 64'(n));
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  m;
        bit          seen [256];
        int          cnt;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // q0 on 0x00, 0x01 back to back: latency and throughput.
        clear_q();
        send(32'h0000_0000, 4'b0000);
        send(32'h0101_0101, 4'b0000);
        in_valid = 1'b0;
        wait_outs(2, 20);
        if (oq.size() >= 2 && ic.size() >= 2) begin
            check_eq("q0_00", oq[0], 32'hA9A9_A9A9);
            check_eq("q0_01", oq[1], 32'h6767_6767);
            check_eq("latency0", 64'(oc[0] - ic[0]), 64'd2);
            check_eq("latency1", 64'(oc[1] - ic[1]), 64'd2);
            check_eq("throughput", 64'(oc[1] - oc[0]), 64'd1);
        end

        // q1 on 0x00, 0x01.
        clear_q();
        send(32'h0000_0000, 4'b1111);
        send(32'h0101_0101, 4'b1111);
        in_valid = 1'b0;
        wait_outs(2, 20);
        if (oq.size() >= 2) begin
            check_eq("q1_00", oq[0], 32'h7575_7575);
            check_eq("q1_01", oq[1], 32'hF3F3_F3F3);
        end

        // Mixed lane modes.
        clear_q();
        send(32'h0001_0001, 4'b1010);
        in_valid = 1'b0;
        wait_outs(1, 20);
        if (oq.size() >= 1) check_eq("mixed_lanes", oq[0], 32'h7567_7567);

        // Full byte sweep in both modes under random backpressure.
        for (int p = 0; p < 2; p++) begin
            clear_q();
            m = (p == 0) ? 4'b1010 : 4'b0101;
            rand_en = 1'b1;
            for (int i = 0; i < 256; i++) begin
                d = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
                eq.push_back({ref_q(m[3], d[31:24]), ref_q(m[2], d[23:16]),
                              ref_q(m[1], d[15:8]),  ref_q(m[0], d[7:0])});
                send(d, m);
            end
            in_valid = 1'b0;
            wait_outs(256, 3000);
            rand_en = 1'b0;
            out_ready = 1'b1;
            for (int j = 0; j < 256; j++) seen[j] = 1'b0;
            for (int j = 0; j < oq.size() && j < 256; j++) begin
                check_eq($sformatf("stream%0d_%0d", p, j), oq[j], eq[j]);
                seen[oq[j][7:0]] = 1'b1;
            end
            cnt = 0;
            for (int j = 0; j < 256; j++) cnt += int'(seen[j]);
            check_eq($sformatf("perm_mode%0d", p), 64'(cnt), 64'd256);
        end
        @(posedge clk);
        #1;

        // Fill with out_ready low, then flush together with an input.
        clear_q();
        out_ready = 1'b0;
        send(32'h1111_1111, 4'b0000);
        send(32'h2222_2222, 4'b0000);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("full_in_ready", in_ready, 1'b0);
        check_eq("full_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h3333_3333;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("flush_no_output", 64'(oq.size()), 64'd0);

        // Asynchronous reset between clock edges while streaming.
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        in_mode  = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        check_eq("pre_rst_valid", out_valid, 1'b1);
        check_eq("pre_rst_data", out_data, 32'hA9A9_A9A9);
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", out_valid, 1'b0);
        check_eq("async_rst_data", out_data, 32'd0);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        check_eq("post_rst_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;

`ifdef Q_PERM_PIPE_STATS_EN
        // 10 transfers with exactly 3 stall cycles on the first.
        clear_q();
        out_ready = 1'b0;
        send(32'h0000_0000, 4'b0000);
        in_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("stats_first_valid", out_valid, 1'b1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 1; i < 10; i++) send(32'(i), 4'b0000);
        in_valid = 1'b0;
        wait_outs(10, 40);
        @(posedge clk);
        #1;
        check_eq("stat_xfers", stat_xfers, 32'd10);
        check_eq("stat_stalls", stat_stalls, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
